// File: rtl/rf_phase_sequencer_pkg.sv
// Shared types and constants for the phase sequencer: controller states,
// one-hot phase encodings and default register-file geometry.
package rf_phase_sequencer_pkg;

  localparam int AW_DEF    = 3;
  localparam int DW_DEF    = 32;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    DBG    = 2'd3
  } state_t;

  localparam logic [4:0] PH_NONE = 5'b00000;
  localparam logic [4:0] PH_IF   = 5'b00001;
  localparam logic [4:0] PH_ID   = 5'b00010;
  localparam logic [4:0] PH_EX   = 5'b00100;
  localparam logic [4:0] PH_MEM  = 5'b01000;
  localparam logic [4:0] PH_WB   = 5'b10000;

endpackage

// File: rtl/rf_phase_sequencer_phase_ring.sv
// One-hot phase rotator. Priority: clear, then load, then hold, else rotate left.
module phase_ring
  import rf_phase_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       load,
  input  logic [4:0] load_val,
  input  logic       hold,
  output logic [4:0] phase
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase <= PH_NONE;
    end else if (clear) begin
      phase <= PH_NONE;
    end else if (load) begin
      phase <= load_val;
    end else if (!hold) begin
      phase <= {phase[3:0], phase[4]};
    end
  end

endmodule

// File: rtl/rf_phase_sequencer.sv
// Phase sequencer: steps the core through five one-hot phases, counts retired
// instructions and arbitrates register-file access between core and debug port.
module rf_phase_sequencer
  import rf_phase_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic             stall,
  input  logic [AW-1:0]    core_ra1,
  input  logic [AW-1:0]    core_ra2,
  input  logic [AW-1:0]    core_wa,
  input  logic [DW-1:0]    core_wd,
  input  logic             core_we,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [AW-1:0]    dbg_addr,
  input  logic [DW-1:0]    dbg_wdata,
  input  logic [DW-1:0]    rf_rd1,
  output logic [AW-1:0]    rf_ra1,
  output logic [AW-1:0]    rf_ra2,
  output logic [AW-1:0]    rf_wa,
  output logic [DW-1:0]    rf_wd,
  output logic             rf_we,
  output logic [4:0]       phase,
  output logic             dbg_ack,
  output logic [DW-1:0]    dbg_rdata,
  output logic             running,
  output logic [CNT_W-1:0] inst_count
);

  state_t     state, state_nxt, ret_state;
  logic       save_ret;
  logic       ring_clear, ring_load, ring_hold;
  logic [4:0] ring_val;
  logic       cnt_inc;

  phase_ring u_phase_ring (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (ring_clear),
    .load     (ring_load),
    .load_val (ring_val),
    .hold     (ring_hold),
    .phase    (phase)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      ret_state  <= IDLE;
      inst_count <= '0;
    end else begin
      state <= state_nxt;
      if (save_ret) ret_state  <= state;
      if (cnt_inc)  inst_count <= inst_count + 1'b1;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    save_ret   = 1'b0;
    ring_clear = 1'b0;
    ring_load  = 1'b0;
    ring_val   = PH_NONE;
    ring_hold  = 1'b1;
    cnt_inc    = 1'b0;
    unique case (state)
      IDLE, HALTED: begin
        if (dbg_req) begin
          state_nxt = DBG;
          save_ret  = 1'b1;
          ring_load = 1'b1;
          ring_val  = PH_WB;
        end else if (start) begin
          state_nxt = RUN;
          ring_load = 1'b1;
          ring_val  = PH_IF;
        end
      end
      RUN: begin
        if (!stall) begin
          ring_hold = 1'b0;
          // Instruction boundary: writeback phase completing this cycle.
          if (phase[4]) begin
            cnt_inc = 1'b1;
            if (halt_req) begin
              state_nxt  = HALTED;
              ring_clear = 1'b1;
            end
          end
        end
      end
      DBG: begin
        state_nxt  = ret_state;
        ring_clear = 1'b1;
      end
      default: begin
        state_nxt  = IDLE;
        ring_clear = 1'b1;
      end
    endcase
  end

  always_comb begin
    rf_ra1    = core_ra1;
    rf_ra2    = core_ra2;
    rf_wa     = core_wa;
    rf_wd     = core_wd;
    rf_we     = 1'b0;
    dbg_ack   = 1'b0;
    dbg_rdata = '0;
    if (state == DBG) begin
      rf_ra1    = dbg_addr;
      rf_wa     = dbg_addr;
      rf_wd     = dbg_wdata;
      rf_we     = dbg_we;
      dbg_ack   = 1'b1;
      dbg_rdata = rf_rd1;
    end else if (state == RUN) begin
      // Stalled writeback is suppressed so the write commits only on the releasing cycle.
      rf_we = core_we & phase[4] & ~stall;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_rf_phase_sequencer.sv
// Self-checking bench for rf_phase_sequencer with a behavioural 8-word register file.
module tb_rf_phase_sequencer;

  localparam int CW = 4;

  typedef struct {
    logic [4:0]  ctl;   // {rst, start, halt_req, stall, core_we}
    logic [1:0]  dbg;   // {dbg_req, dbg_we}
    logic [2:0]  da;
    logic [31:0] dd;
    logic [4:0]  e_phase;
    logic [2:0]  e_flg; // {running, rf_we, dbg_ack}
    logic [3:0]  e_cnt;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0, halt_req = 1'b0, stall = 1'b0, core_we = 1'b0;
  logic [2:0]    core_ra1 = 3'd1, core_ra2 = 3'd2, core_wa = 3'd3;
  logic [31:0]   core_wd = 32'hDEADBEEF;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [2:0]    dbg_addr = 3'd0;
  logic [31:0]   dbg_wdata = 32'h0;
  logic [31:0]   rf_rd1;
  logic [2:0]    rf_ra1, rf_ra2, rf_wa;
  logic [31:0]   rf_wd;
  logic          rf_we;
  logic [4:0]    phase;
  logic          dbg_ack;
  logic [31:0]   dbg_rdata;
  logic          running;
  logic [CW-1:0] inst_count;

  int   total = 0;
  int   bad = 0;
  vec_t tbl[$];
  vec_t sb[$];
  vec_t got;
  logic [31:0] regs [8];

  rf_phase_sequencer #(.CNT_W(CW), .AW(3), .DW(32)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .halt_req(halt_req), .stall(stall),
    .core_ra1(core_ra1), .core_ra2(core_ra2), .core_wa(core_wa), .core_wd(core_wd),
    .core_we(core_we), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .rf_rd1(rf_rd1), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we), .phase(phase), .dbg_ack(dbg_ack),
    .dbg_rdata(dbg_rdata), .running(running), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  // Register file: writes land only with we=1 during the writeback phase.
  assign rf_rd1 = regs[rf_ra1];
  always @(posedge clk) if (rf_we && phase[4]) regs[rf_wa] <= rf_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] ctl, input logic [1:0] dbg, input logic [2:0] da,
                              input logic [31:0] dd, input logic [4:0] ph, input logic [2:0] flg,
                              input logic [3:0] cnt, input logic crd, input logic [31:0] rd);
    vec_t v;
    v.ctl = ctl; v.dbg = dbg; v.da = da; v.dd = dd;
    v.e_phase = ph; v.e_flg = flg; v.e_cnt = cnt; v.chk_rd = crd; v.e_rd = rd;
    return v;
  endfunction

  // Scoreboard consumer: compares the DUT against the record pushed for this cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("phase", 32'(phase), 32'(got.e_phase));
      check("running", 32'(running), 32'(got.e_flg[2]));
      check("rf_we", 32'(rf_we), 32'(got.e_flg[1]));
      check("dbg_ack", 32'(dbg_ack), 32'(got.e_flg[0]));
      check("inst_count", 32'(inst_count), 32'(got.e_cnt));
      if (got.chk_rd) check("dbg_rdata", dbg_rdata, got.e_rd);
    end
  end

  // Entered #1 after a rising edge; leaves #1 after the next one.
  task automatic apply(input vec_t v);
    {start, halt_req, stall, core_we} = v.ctl[3:0];
    {dbg_req, dbg_we} = v.dbg;
    dbg_addr  = v.da;
    dbg_wdata = v.dd;
    sb.push_back(v);
    if (v.ctl[4]) begin
      #2 n_rst = 1'b0;
    end
    @(negedge clk);
    if (v.ctl[4]) begin
      #1 n_rst = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] ph;
    for (int i = 0; i < 8; i++) regs[i] = 32'h0;

    //                 rst,st,hr,sl,cwe  req,we  addr   wdata          phase     run,we,ack cnt
    tbl.push_back(mk(5'b10000, 2'b00, 3'd0, 32'h0,         5'b00000, 3'b000, 4'd0, 1'b0, 32'h0));
    tbl.push_back(mk(5'b01000, 2'b00, 3'd0, 32'h0,         5'b00000, 3'b000, 4'd0, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00001, 3'b100, 4'd0, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00010, 3'b100, 4'd0, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00100, 3'b100, 4'd0, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b01000, 3'b100, 4'd0, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b10000, 3'b100, 4'd0, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00001, 3'b100, 4'd1, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00010, 3'b100, 4'd1, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00100, 3'b100, 4'd1, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b01000, 3'b100, 4'd1, 1'b0, 32'h0));
    // Stalled writeback of 0xDEADBEEF to r3: three held cycles, then one commit.
    tbl.push_back(mk(5'b00011, 2'b00, 3'd0, 32'h0,         5'b10000, 3'b100, 4'd1, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00011, 2'b00, 3'd0, 32'h0,         5'b10000, 3'b100, 4'd1, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00011, 2'b00, 3'd0, 32'h0,         5'b10000, 3'b100, 4'd1, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00001, 2'b00, 3'd0, 32'h0,         5'b10000, 3'b110, 4'd1, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00001, 3'b100, 4'd2, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00010, 3'b100, 4'd2, 1'b0, 32'h0));
    // Halt requested mid-instruction takes effect at the boundary.
    tbl.push_back(mk(5'b00100, 2'b00, 3'd0, 32'h0,         5'b00100, 3'b100, 4'd2, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00100, 2'b00, 3'd0, 32'h0,         5'b01000, 3'b100, 4'd2, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00100, 2'b00, 3'd0, 32'h0,         5'b10000, 3'b100, 4'd2, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00000, 3'b000, 4'd3, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00000, 3'b000, 4'd3, 1'b0, 32'h0));
    tbl.push_back(mk(5'b01000, 2'b00, 3'd0, 32'h0,         5'b00000, 3'b000, 4'd3, 1'b0, 32'h0));
    // Resumed; dbg_req during RUN stays unacknowledged until the halt.
    tbl.push_back(mk(5'b00100, 2'b00, 3'd0, 32'h0,         5'b00001, 3'b100, 4'd3, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00100, 2'b10, 3'd0, 32'h0,         5'b00010, 3'b100, 4'd3, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00100, 2'b10, 3'd0, 32'h0,         5'b00100, 3'b100, 4'd3, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00100, 2'b10, 3'd0, 32'h0,         5'b01000, 3'b100, 4'd3, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00100, 2'b10, 3'd0, 32'h0,         5'b10000, 3'b100, 4'd3, 1'b0, 32'h0));
    // Debug write r5 then read r5 from HALTED.
    tbl.push_back(mk(5'b00000, 2'b11, 3'd5, 32'h12345678,  5'b00000, 3'b000, 4'd4, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b11, 3'd5, 32'h12345678,  5'b10000, 3'b011, 4'd4, 1'b1, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b10, 3'd5, 32'h0,         5'b00000, 3'b000, 4'd4, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd5, 32'h0,         5'b10000, 3'b001, 4'd4, 1'b1, 32'h12345678));
    tbl.push_back(mk(5'b01000, 2'b00, 3'd0, 32'h0,         5'b00000, 3'b000, 4'd4, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00001, 3'b100, 4'd4, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00010, 3'b100, 4'd4, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00100, 3'b100, 4'd4, 1'b0, 32'h0));
    // Reset during phase 01000 with a pending core write.
    tbl.push_back(mk(5'b10001, 2'b00, 3'd0, 32'h0,         5'b00000, 3'b000, 4'd0, 1'b0, 32'h0));
    // dbg_req and start together in IDLE: debug read of r3 first, then RUN.
    tbl.push_back(mk(5'b01000, 2'b10, 3'd3, 32'h0,         5'b00000, 3'b000, 4'd0, 1'b0, 32'h0));
    tbl.push_back(mk(5'b01000, 2'b00, 3'd3, 32'h0,         5'b10000, 3'b001, 4'd0, 1'b1, 32'hDEADBEEF));
    tbl.push_back(mk(5'b01000, 2'b00, 3'd0, 32'h0,         5'b00000, 3'b000, 4'd0, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00001, 3'b100, 4'd0, 1'b0, 32'h0));
    tbl.push_back(mk(5'b10000, 2'b00, 3'd0, 32'h0,         5'b00000, 3'b000, 4'd0, 1'b0, 32'h0));
    // Reset during a debug write to r6 must abort it; readback shows r6 untouched.
    tbl.push_back(mk(5'b00000, 2'b11, 3'd6, 32'hBAD0BAD0,  5'b00000, 3'b000, 4'd0, 1'b0, 32'h0));
    tbl.push_back(mk(5'b10000, 2'b01, 3'd6, 32'hBAD0BAD0,  5'b00000, 3'b000, 4'd0, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b10, 3'd6, 32'h0,         5'b00000, 3'b000, 4'd0, 1'b0, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd6, 32'h0,         5'b10000, 3'b001, 4'd0, 1'b1, 32'h0));
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00000, 3'b000, 4'd0, 1'b0, 32'h0));
    // Sixteen back-to-back instructions wrap the 4-bit counter to zero.
    tbl.push_back(mk(5'b01000, 2'b00, 3'd0, 32'h0,         5'b00000, 3'b000, 4'd0, 1'b0, 32'h0));
    for (int k = 0; k < 80; k++) begin
      ph = 5'b00001 << (k % 5);
      tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0, ph, 3'b100, 4'((k / 5) % 16), 1'b0, 32'h0));
    end
    tbl.push_back(mk(5'b00000, 2'b00, 3'd0, 32'h0,         5'b00001, 3'b100, 4'd0, 1'b0, 32'h0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);

    check("reg3", regs[3], 32'hDEADBEEF);
    check("reg5", regs[5], 32'h12345678);
    check("reg6", regs[6], 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
